// File: rtl/uart_tx.sv
// uart_tx - buffered UART transmitter.
//
// Bytes written on the user port are queued in a small synchronous FIFO and
// sent as frames of 1 start bit, 8 data bits (LSB first), an optional parity
// bit and 1 or 2 stop bits. When another byte is waiting at the end of the
// stop period, its start bit follows with no idle gap.
//
// Parameters:
//   CLK_DIV   - clock cycles per UART bit (>= 2)
//   PARITY    - "NONE", "ODD" or "EVEN"
//   STOP_BITS - 1 or 2
//   FIFO_EA   - FIFO address width, depth = 2**FIFO_EA (>= 1)
//
// Ports:
//   clk        - clock, rising edge
//   rstn       - synchronous active-low reset
//   tx_data    - byte to transmit, sampled only on an accepted write
//   tx_en      - write strobe, accepted when tx_rdy is high
//   tx_rdy     - FIFO not full (registered)
//   o_uart_tx  - serial line, idle high (registered)
module uart_tx #(
  parameter int unsigned CLK_DIV   = 434,
  parameter string       PARITY    = "NONE",
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned FIFO_EA   = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic [7:0] tx_data,
  input  logic       tx_en,
  output logic       tx_rdy,
  output logic       o_uart_tx
);

  localparam int unsigned DEPTH = 1 << FIFO_EA;
  localparam int unsigned CW    = FIFO_EA + 1;
  localparam int unsigned TW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic        PAR_EN  = (PARITY != "NONE");
  localparam logic        PAR_ODD = (PARITY == "ODD");

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARI,
    S_STOP
  } state_t;

  // ---------------------------------------------------------------------------
  // FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]         mem_q [DEPTH];
  logic [FIFO_EA-1:0] wr_ptr_q;
  logic [FIFO_EA-1:0] rd_ptr_q;
  logic [CW-1:0]      count_q;
  logic [CW-1:0]      count_d;
  logic               tx_rdy_q;
  logic               avail_q;
  logic [7:0]         rd_data_q;
  logic               wr_en;
  logic               pop;

  // Fullness comes from the registered count only, so a pop in the same
  // cycle never opens a slot early.
  assign wr_en = tx_en & tx_rdy_q;

  always_comb begin
    count_d = count_q + CW'(wr_en) - CW'(pop);
  end

  // Block-RAM style storage: registered read of the head entry every cycle.
  always_ff @(posedge clk) begin
    if (rstn && wr_en) begin
      mem_q[wr_ptr_q] <= tx_data;
    end
    rd_data_q <= mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      tx_rdy_q <= 1'b1;
      avail_q  <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + FIFO_EA'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + FIFO_EA'(1);
      end
      count_q  <= count_d;
      tx_rdy_q <= (count_d != CW'(DEPTH));
      // avail_q trails the count by one cycle so that it only rises once
      // rd_data_q holds the current head. It is dropped on a pop because the
      // read register still shows the entry just consumed for one more cycle.
      avail_q  <= (count_q != '0) && !pop;
    end
  end

  // ---------------------------------------------------------------------------
  // Transmit FSM
  // ---------------------------------------------------------------------------
  state_t         state_q, state_d;
  logic [TW-1:0]  timer_q, timer_d;
  logic [3:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]     shift_q, shift_d;
  logic           parity_q, parity_d;
  logic           tx_q, tx_d;
  logic           bit_end;

  assign bit_end = (timer_q == TW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      timer_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    pop       = 1'b0;
    // The bit timer free-runs while a frame is on the line and wraps at the
    // end of every bit, so bit boundaries never drift.
    if (state_q == S_IDLE || bit_end) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    unique case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (avail_q) begin
          pop      = 1'b1;
          shift_d  = rd_data_q;
          parity_d = (^rd_data_q) ^ PAR_ODD;
          tx_d     = 1'b0;
          state_d  = S_START;
        end
      end

      S_START: begin
        if (bit_end) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (bit_end) begin
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            if (PAR_EN) begin
              tx_d    = parity_q;
              state_d = S_PARI;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[7:1]};
          end
        end
      end

      S_PARI: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          tx_d      = 1'b1;
          state_d   = S_STOP;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (bit_cnt_q == 4'(STOP_BITS - 1)) begin
            bit_cnt_d = '0;
            if (avail_q) begin
              // Chain straight into the next start bit.
              pop      = 1'b1;
              shift_d  = rd_data_q;
              parity_d = (^rd_data_q) ^ PAR_ODD;
              tx_d     = 1'b0;
              state_d  = S_START;
            end else begin
              tx_d    = 1'b1;
              state_d = S_IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  assign tx_rdy    = tx_rdy_q;
  assign o_uart_tx = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx - self-checking bench for uart_tx.
//
// Three configurations run side by side:
//   cfg0: CLK_DIV=4, PARITY="NONE", STOP_BITS=1, FIFO_EA=2
//   cfg1: CLK_DIV=4, PARITY="EVEN", STOP_BITS=1, FIFO_EA=2
//   cfg2: CLK_DIV=8, PARITY="ODD",  STOP_BITS=2, FIFO_EA=1
// Each is driven by a directed prologue (single byte, full-FIFO burst, reset
// mid-frame) followed by random writes and occasional resets. A reference
// model keeps the list of scheduled frames (start edge + byte) and from it
// predicts the line level and tx_rdy after every clock edge.
module tb_uart_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_cfg
    localparam int CD    = (gi == 2) ? 8 : 4;
    localparam int PM    = gi;                 // 0 none, 1 even, 2 odd
    localparam int SB    = (gi == 2) ? 2 : 1;
    localparam int EA    = (gi == 2) ? 1 : 2;
    localparam int DEPTH = 1 << EA;
    localparam int FLEN  = (10 + ((PM != 0) ? 1 : 0) + (SB - 1)) * CD;
    localparam logic [7:0] FIRST_BYTE = (gi == 0) ? 8'h55 : (gi == 1) ? 8'h07 : 8'h00;

    typedef struct {
      int         start;
      logic [7:0] d;
    } frame_t;

    logic       rstn_r = 1'b0;
    logic       en_r   = 1'b0;
    logic [7:0] data_r = 8'h00;
    logic       rdy_w;
    logic       line_w;
    bit         done_r = 1'b0;
    frame_t     fq[$];
    int         obs_acc = 0;

    if (gi == 0) begin : g_dut
      uart_tx #(.CLK_DIV(CD), .PARITY("NONE"), .STOP_BITS(SB), .FIFO_EA(EA)) u_dut (
        .clk(clk), .rstn(rstn_r), .tx_data(data_r), .tx_en(en_r),
        .tx_rdy(rdy_w), .o_uart_tx(line_w)
      );
    end else if (gi == 1) begin : g_dut
      uart_tx #(.CLK_DIV(CD), .PARITY("EVEN"), .STOP_BITS(SB), .FIFO_EA(EA)) u_dut (
        .clk(clk), .rstn(rstn_r), .tx_data(data_r), .tx_en(en_r),
        .tx_rdy(rdy_w), .o_uart_tx(line_w)
      );
    end else begin : g_dut
      uart_tx #(.CLK_DIV(CD), .PARITY("ODD"), .STOP_BITS(SB), .FIFO_EA(EA)) u_dut (
        .clk(clk), .rstn(rstn_r), .tx_data(data_r), .tx_en(en_r),
        .tx_rdy(rdy_w), .o_uart_tx(line_w)
      );
    end

    // Called at a falling edge: checks the outputs produced by the last
    // rising edge, then applies inputs for the next one.
    task automatic step(input logic r, input logic e, input logic [7:0] d);
      int t;
      int p;
      int pend;
      int start;
      logic el;
      logic er;
      t = cyc;
      while (fq.size() > 0 && fq[0].start + FLEN <= t) void'(fq.pop_front());
      el = 1'b1;
      if (fq.size() > 0 && fq[0].start <= t) begin
        p = (t - fq[0].start) / CD;
        if (p == 0) el = 1'b0;
        else if (p <= 8) el = fq[0].d[p-1];
        else if (p == 9 && PM != 0) el = (PM == 2) ? ~(^fq[0].d) : ^fq[0].d;
      end
      pend = 0;
      foreach (fq[i]) if (fq[i].start > t) pend++;
      er = (pend != DEPTH);
      chk($sformatf("cfg%0d line@%0d", gi, t), {31'd0, line_w}, {31'd0, el});
      chk($sformatf("cfg%0d rdy@%0d", gi, t), {31'd0, rdy_w}, {31'd0, er});
      if (r && e && rdy_w === 1'b1) obs_acc++;
      rstn_r = r;
      en_r   = e;
      data_r = d;
      if (!r) begin
        fq.delete();
        $display("cfg%0d: reset at edge %0d", gi, t + 1);
      end else if (e && er) begin
        start = t + 3;
        if (fq.size() > 0 && fq[$].start + FLEN > start) start = fq[$].start + FLEN;
        fq.push_back(frame_t'{start, d});
        $display("cfg%0d: byte %02h accepted at edge %0d, frame from edge %0d",
                 gi, d, t + 1, start);
      end
      @(negedge clk);
    endtask

    task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0, 8'h00);
    endtask

    task automatic drain();
      int guard = 0;
      while (fq.size() > 0 && guard < 5000) begin
        step(1'b1, 1'b0, 8'h00);
        guard++;
      end
      idle(FLEN / 2);
    endtask

    initial begin
      @(negedge clk);
      repeat (3) step(1'b0, 1'b0, 8'h00);

      // Single frame with a known byte, then the line must stay idle.
      step(1'b1, 1'b1, FIRST_BYTE);
      idle(FLEN + 8);

      // tx_en held high from empty: exactly DEPTH+1 writes get in.
      obs_acc = 0;
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 8'(i + 1));
      chk($sformatf("cfg%0d burst_accepts", gi), obs_acc, DEPTH + 1);
      drain();

      // Three bytes queued, reset in the middle of the data bits.
      step(1'b1, 1'b1, 8'hA5);
      idle(3);
      step(1'b1, 1'b1, 8'h3C);
      step(1'b1, 1'b1, 8'hC3);
      idle(3 * CD);
      step(1'b0, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      idle(FLEN + 10);

      // Random traffic with rare resets.
      for (int k = 0; k < 1500; k++) begin
        if ($urandom_range(0, 599) == 0) step(1'b0, 1'b0, 8'h00);
        else step(1'b1, 1'($urandom_range(0, 3) == 0), 8'($urandom));
      end
      drain();
      done_r = 1'b1;
    end
  end

  initial begin
    int guard = 0;
    while (!(g_cfg[0].done_r && g_cfg[1].done_r && g_cfg[2].done_r) && guard < 60000) begin
      @(posedge clk);
      guard++;
    end
    chk("all_cfgs_finished",
        {31'd0, (g_cfg[0].done_r && g_cfg[1].done_r && g_cfg[2].done_r)}, 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
